// File: rtl/reg_snapshot_tx_pkg.sv
// Shared definitions for the register snapshot serialiser: FSM state codes,
// default data width and the bit-counter width rule.
package reg_snapshot_tx_pkg;

  localparam int DEFAULT_WIDTH = 8;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  // Counter must reach WIDTH+1 (data plus optional parity) without wrapping.
  function automatic int cnt_width(input int width);
    return $clog2(width + 2);
  endfunction

endpackage

// File: rtl/reg_snapshot_tx_if.sv
// Request/serial-output bundle between a requester and reg_snapshot_tx.
interface reg_snapshot_tx_if #(
  parameter int WIDTH = reg_snapshot_tx_pkg::DEFAULT_WIDTH
);

  logic             req;
  logic [WIDTH-1:0] data_in;
  logic             sout;
  logic             sout_valid;
  logic             busy;
  logic             done;

  modport master (
    output req, data_in,
    input  sout, sout_valid, busy, done
  );

  modport slave (
    input  req, data_in,
    output sout, sout_valid, busy, done
  );

endinterface

// File: rtl/reg_snapshot_tx_bit_counter.sv
// Saturating up-counter tracking how many bits of a transfer have been driven.
module bit_counter #(
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          res,
  input  logic          en,
  input  logic          clear,
  output logic [CW-1:0] count
);

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!res) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (en && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/reg_snapshot_tx.sv
// Snapshots a parallel register value on request and shifts it out serially,
// optionally followed by an even-parity bit, then pulses done for one cycle.
module reg_snapshot_tx
  import reg_snapshot_tx_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter int MSB_FIRST = 1,
  parameter int PARITY_EN = 0
) (
  input  logic               clk,
  input  logic               res,
  input  logic               en,
  reg_snapshot_tx_if.slave   bus
);

  localparam int              CW        = cnt_width(WIDTH);
  localparam logic [CW-1:0]   DATA_LAST = CW'(WIDTH);
  localparam logic [CW-1:0]   XFER_LAST = CW'(WIDTH + PARITY_EN);

  logic [1:0]       state;
  logic [WIDTH-1:0] shreg;
  logic             parity;
  logic             sout_q;
  logic             sout_valid_q;
  logic             busy_q;
  logic             done_q;
  logic [CW-1:0]    count;
  logic             cnt_inc;
  logic             cnt_clr;

  // NOTE: every always_comb output gets a default first so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    cnt_inc = 1'b0;
    cnt_clr = 1'b0;
    if (en) begin
      case (state)
        ST_IDLE:  cnt_inc = bus.req;
        ST_SHIFT: cnt_inc = (count != XFER_LAST);
        default:  cnt_clr = 1'b1;
      endcase
    end
  end

  bit_counter #(.CW(CW)) u_bit_counter (
    .clk   (clk),
    .res   (res),
    .en    (cnt_inc),
    .clear (cnt_clr),
    .count (count)
  );

  // count holds the number of bits already driven onto sout.
  // NOTE: the shift register is reset along with control state because the
  // reset contract leaves no stale snapshot behind after an abort.
  always_ff @(posedge clk) begin
    if (!res) begin
      state        <= ST_IDLE;
      shreg        <= '0;
      parity       <= 1'b0;
      sout_q       <= 1'b0;
      sout_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else if (!en) begin
      sout_valid_q <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      sout_valid_q <= 1'b0;
      done_q       <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.req) begin
            state        <= ST_SHIFT;
            busy_q       <= 1'b1;
            sout_valid_q <= 1'b1;
            parity       <= ^bus.data_in;
            if (MSB_FIRST != 0) begin
              sout_q <= bus.data_in[WIDTH-1];
              shreg  <= bus.data_in << 1;
            end else begin
              sout_q <= bus.data_in[0];
              shreg  <= bus.data_in >> 1;
            end
          end
        end
        ST_SHIFT: begin
          if (count < DATA_LAST) begin
            sout_valid_q <= 1'b1;
            if (MSB_FIRST != 0) begin
              sout_q <= shreg[WIDTH-1];
              shreg  <= shreg << 1;
            end else begin
              sout_q <= shreg[0];
              shreg  <= shreg >> 1;
            end
          end else if (count < XFER_LAST) begin
            sout_valid_q <= 1'b1;
            sout_q       <= parity;
          end else begin
            state  <= ST_DONE;
            done_q <= 1'b1;
          end
        end
        default: begin
          state  <= ST_IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.sout       = sout_q;
  assign bus.sout_valid = sout_valid_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;

endmodule
